load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit for the RISC-V core. Takes the effective-address operands and store data read from the register file, runs one data-memory transaction over a ready-handshake bus, and produces the sign/zero-extended load result with its write strobe for the register file write port. While a transaction is in flight it raises `busy` so the core stalls. It reports misaligned, illegal and timed-out accesses as a one-cycle fault.

## Interface
- `TIMEOUT`, default 16: maximum REQ cycles without `mem_ready` before a bus fault; 0 disables the timeout.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a memory operation; sampled only in IDLE.
- `is_load`, `is_store`  in  1 each  operation type; exactly one must be high, otherwise `start` is ignored.
- `funct3`  in  3  RV32I width/sign: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
- `base`  in  32  rs1 data.
- `offset`  in  32  sign-extended immediate.
- `store_data`  in  32  rs2 data.
- `rd_in`  in  5  load destination register.
- `mem_req`  out  1  transaction request.
- `mem_we`  out  1  1 = store.
- `mem_addr`  out  32  word address, bits [1:0] forced to 00.
- `mem_wstrb`  out  4  byte lane enables; 0000 for loads.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  completes the current transaction.
- `mem_rdata`  in  32  read word; valid with `mem_ready` on loads.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rd_out`  out  5  destination register.
- `rd_we`  out  1  register-file write enable.
- `rd_wdata`  out  32  extended load result.
- `fault`  out  1  one-cycle fault pulse.
- `fault_cause`  out  2  01 misaligned, 10 bus timeout, 11 illegal funct3.
- `fault_addr`  out  32  full byte effective address of the faulting access.

## Operation
- States: IDLE, REQ, WB, FAULT.
- **Address:** `addr = base + offset`, modulo 2^32; carry is discarded.
- **IDLE:** a valid `start` latches `addr`, `funct3`, `store_data`, `rd_in` and the operation type. Checks run in this order:
  - Illegal funct3 (load 011/110/111; store ≥011): go to FAULT, cause 11.
  - Misaligned access (H with `addr[0]`=1, W with `addr[1:0]`≠00): go to FAULT, cause 01.
  - Otherwise go to REQ and clear the timeout counter.
- **REQ:**
  - `mem_req`=1; `mem_we`, `mem_addr`, `mem_wstrb` and `mem_wdata` are driven from latched values and held stable until `mem_ready`.
  - On `mem_ready`, loads capture `mem_rdata`, then go to WB.
  - Otherwise the counter increments. If `TIMEOUT`≠0 and the counter reaches `TIMEOUT`, go to FAULT, cause 10.
  - If `mem_ready` arrives in the same cycle the counter would expire, `mem_ready` wins.
- **Store lanes:** `k = addr[1:0]`.
  - SB: `wstrb = 0001<<k`, `wdata = {4{sd[7:0]}}`.
  - SH: `wstrb = 0011<<k`, `wdata = {2{sd[15:0]}}`.
  - SW: `wstrb = 1111`.
- **Load extract:** byte = `rdata[8k+7:8k]`; half = `rdata[16·addr[1]+15:16·addr[1]]`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- **WB:**
  - `done`=1 for one cycle.
  - Loads: `rd_we`=1 only if `rd_out`≠0; `rd_wdata` = extracted value.
  - Stores: `rd_we`=0, `rd_wdata`=0.
  - Next state IDLE.
- **FAULT:** `fault`=1 for one cycle with `fault_cause` and `fault_addr`; `done`=0, `rd_we`=0, no memory request. Next state IDLE.
- `start` while `busy` is ignored.

## Timing
- **Reset:** all outputs 0, state IDLE, counter 0. Reset takes effect immediately, including mid-REQ: `mem_req` drops asynchronously and no `done`, `rd_we` or `fault` is produced for the aborted access.
- **Latency:** `start` sampled at edge 0 gives REQ in cycle 1. If `mem_ready` is high in cycle 1, WB (`done`, `rd_we`) is in cycle 2. Minimum 3 cycles start-to-IDLE; each wait cycle adds 1.
- **Fault latency:** `fault` is asserted the cycle after `start` for illegal/misaligned accesses, and the cycle after REQ cycle `TIMEOUT` for timeouts.
- `rd_out`, `rd_wdata`, `fault_addr`, `fault_cause` are valid only while `done`/`fault` is high and zero otherwise.
- `busy` is high in REQ, WB and FAULT. The core may issue the next `start` in the cycle after WB or FAULT.

## Test plan
- LB, base=0x100, offset=3, rdata=0x80FF_1234, ready in first REQ cycle → `mem_addr`=0x100, `rd_wdata`=0xFFFF_FF80, `done`+`rd_we` in cycle 2.
- SH, base=0x200, offset=2, sd=0xAAAA_BEEF, `mem_ready` after 3 wait cycles → `wstrb`=1100, `wdata`=0xBEEF_BEEF, request held stable, `done` in cycle 5, `rd_we`=0.
- LW at addr 0x101 → cycle 1 `fault`=1, cause 01, `fault_addr`=0x101, `mem_req` never asserted. Load funct3=011 → cause 11.
- `TIMEOUT`=4, `mem_ready` tied low → 4 REQ cycles then `fault` cause 10, back to IDLE. Repeat with ready in REQ cycle 4 → normal `done`, no fault.
- LHU with `rd_in`=0, rdata=0x1234_8001, addr 0x2 → `done`=1, `rd_we`=0. Same with `rd_in`=5 → `rd_wdata`=0x0000_1234.
- Assert `reset` during REQ → `mem_req` low the same cycle, all outputs 0, IDLE. `start` pulsed while `busy` → no second transaction.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: one data-memory transaction per start over a
// ready-handshake bus, with load extension, store lane steering and fault reporting.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rd_out,
  output logic        rd_we,
  output logic [31:0] rd_wdata,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WB, FAULT} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sd_q, sd_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        load_q, load_d;
  logic [1:0]  cause_q, cause_d;

  logic [31:0] eff_addr;
  logic        illegal, misaligned;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] k,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{k, 3'b000} +: 8];
    h = w[{k[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] k);
    case (f3[1:0])
      2'b00:   return 4'b0001 << k;
      2'b01:   return 4'b0011 << k;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  assign eff_addr   = base + offset;
  assign illegal    = is_load ? (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                              : (funct3 >= 3'b011);
  assign misaligned = (funct3[1:0] == 2'b01 && eff_addr[0]) ||
                      (funct3[1:0] == 2'b10 && eff_addr[1:0] != 2'b00);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sd_d        = sd_q;
    rdata_d     = rdata_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    load_d      = load_q;
    cause_d     = cause_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wstrb   = 4'd0;
    mem_wdata   = 32'd0;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    rd_out      = 5'd0;
    rd_we       = 1'b0;
    rd_wdata    = 32'd0;
    fault       = 1'b0;
    fault_cause = 2'd0;
    fault_addr  = 32'd0;

    case (state_q)
      IDLE: begin
        if (start && (is_load ^ is_store)) begin
          addr_d = eff_addr;
          f3_d   = funct3;
          sd_d   = store_data;
          rd_d   = rd_in;
          load_d = is_load;
          cnt_d  = 32'd0;
          // Illegal encoding takes priority over alignment.
          if (illegal) begin
            cause_d = 2'b11;
            state_d = FAULT;
          end else if (misaligned) begin
            cause_d = 2'b01;
            state_d = FAULT;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_we   = ~load_q;
        mem_addr = {addr_q[31:2], 2'b00};
        if (!load_q) begin
          mem_wstrb = store_strb(f3_q, addr_q[1:0]);
          mem_wdata = store_lanes(f3_q, sd_q);
        end
        if (mem_ready) begin
          if (load_q) rdata_d = mem_rdata;
          state_d = WB;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if (TIMEOUT != 0 && cnt_d == 32'(TIMEOUT)) begin
            cause_d = 2'b10;
            state_d = FAULT;
          end
        end
      end
      WB: begin
        done = 1'b1;
        if (load_q) begin
          rd_out   = rd_q;
          rd_we    = (rd_q != 5'd0);
          rd_wdata = load_extract(f3_q, addr_q[1:0], rdata_q);
        end
        state_d = IDLE;
      end
      FAULT: begin
        fault       = 1'b1;
        fault_cause = cause_q;
        fault_addr  = addr_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state_q, so an asynchronous reset drops the bus request at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    sd_q    <= sd_d;
    rdata_q <= rdata_d;
    f3_q    <= f3_d;
    rd_q    <= rd_d;
    load_q  <= load_d;
    cause_q <= cause_d;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit, built with a short bus timeout of 4 cycles.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] base, offset, store_data;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy, done, rd_we, fault;
  logic [4:0]  rd_out;
  logic [31:0] rd_wdata, fault_addr;
  logic [1:0]  fault_cause;

  int total = 0;
  int bad   = 0;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .base(base), .offset(offset), .store_data(store_data), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .rd_out(rd_out), .rd_we(rd_we), .rd_wdata(rd_wdata), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] o, input logic [31:0] sd, input logic [4:0] rd);
    start = 1'b1; is_load = ld; is_store = ~ld; funct3 = f3;
    base = b; offset = o; store_data = sd; rd_in = rd;
  endtask

  task automatic all_quiet(input string tag);
    check({tag, "_req"},   {31'd0, mem_req}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
    check({tag, "_rdwe"},  {31'd0, rd_we}, 32'd0);
    check({tag, "_wdata"}, rd_wdata, 32'd0);
    check({tag, "_faddr"}, fault_addr, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    base = 32'd0; offset = 32'd0; store_data = 32'd0; rd_in = 5'd0;
    mem_ready = 1'b0; mem_rdata = 32'd0;
    #3;
    all_quiet("rst");
    tick(); tick();
    reset = 1'b0;
    tick();

    // LB from 0x103: top byte 0x80 sign-extends
    issue(1'b1, 3'b000, 32'h100, 32'd3, 32'd0, 5'd7);
    tick();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h80FF_1234;
    check("lb_req", {31'd0, mem_req}, 32'd1);
    check("lb_we", {31'd0, mem_we}, 32'd0);
    check("lb_addr", mem_addr, 32'h100);
    check("lb_strb", {28'd0, mem_wstrb}, 32'd0);
    tick();
    mem_ready = 1'b0;
    check("lb_done", {31'd0, done}, 32'd1);
    check("lb_rdwe", {31'd0, rd_we}, 32'd1);
    check("lb_rdout", {27'd0, rd_out}, 32'd7);
    check("lb_wdata", rd_wdata, 32'hFFFF_FF80);
    tick();
    check("lb_idle", {31'd0, busy}, 32'd0);

    // SH to 0x202 with three wait cycles
    issue(1'b0, 3'b001, 32'h200, 32'd2, 32'hAAAA_BEEF, 5'd9);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) mem_ready = 1'b1;
      check($sformatf("sh_req_c%0d", c), {31'd0, mem_req}, 32'd1);
      check($sformatf("sh_we_c%0d", c), {31'd0, mem_we}, 32'd1);
      check($sformatf("sh_addr_c%0d", c), mem_addr, 32'h200);
      check($sformatf("sh_strb_c%0d", c), {28'd0, mem_wstrb}, 32'hC);
      check($sformatf("sh_wdata_c%0d", c), mem_wdata, 32'hBEEF_BEEF);
      check($sformatf("sh_done_c%0d", c), {31'd0, done}, 32'd0);
      tick();
    end
    mem_ready = 1'b0;
    check("sh_done", {31'd0, done}, 32'd1);
    check("sh_rdwe", {31'd0, rd_we}, 32'd0);
    check("sh_wdata", rd_wdata, 32'd0);
    tick();

    // SB to 0x401: lane 1
    issue(1'b0, 3'b000, 32'h400, 32'd1, 32'h1234_56A5, 5'd0);
    tick();
    start = 1'b0; mem_ready = 1'b1;
    check("sb_strb", {28'd0, mem_wstrb}, 32'h2);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_addr", mem_addr, 32'h400);
    tick();
    mem_ready = 1'b0;
    check("sb_done", {31'd0, done}, 32'd1);
    tick();

    // Misaligned LW at 0x101
    issue(1'b1, 3'b010, 32'h100, 32'd1, 32'd0, 5'd4);
    tick();
    start = 1'b0;
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_cause", {30'd0, fault_cause}, 32'd1);
    check("mis_faddr", fault_addr, 32'h101);
    check("mis_req", {31'd0, mem_req}, 32'd0);
    check("mis_done", {31'd0, done}, 32'd0);
    tick();
    check("mis_fault_gone", {31'd0, fault}, 32'd0);
    check("mis_req2", {31'd0, mem_req}, 32'd0);
    check("mis_idle", {31'd0, busy}, 32'd0);

    // Illegal load funct3 011 at a misaligned address: illegal wins
    issue(1'b1, 3'b011, 32'h100, 32'd1, 32'd0, 5'd4);
    tick();
    start = 1'b0;
    check("ill_fault", {31'd0, fault}, 32'd1);
    check("ill_cause", {30'd0, fault_cause}, 32'd3);
    check("ill_req", {31'd0, mem_req}, 32'd0);
    tick();

    // Start with both types high is ignored
    issue(1'b1, 3'b010, 32'h100, 32'd0, 32'd0, 5'd4);
    is_store = 1'b1;
    tick();
    start = 1'b0;
    check("both_busy", {31'd0, busy}, 32'd0);
    check("both_req", {31'd0, mem_req}, 32'd0);

    // Timeout: four REQ cycles then fault cause 10
    issue(1'b1, 3'b010, 32'h2FF, 32'd1, 32'd0, 5'd4);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("to_req_c%0d", c), {31'd0, mem_req}, 32'd1);
      check($sformatf("to_fault_c%0d", c), {31'd0, fault}, 32'd0);
      tick();
    end
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_cause", {30'd0, fault_cause}, 32'd2);
    check("to_faddr", fault_addr, 32'h300);
    check("to_req_off", {31'd0, mem_req}, 32'd0);
    tick();
    check("to_idle", {31'd0, busy}, 32'd0);

    // Ready in REQ cycle 4 beats the timeout
    issue(1'b1, 3'b010, 32'h300, 32'd0, 32'd0, 5'd3);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    mem_ready = 1'b0;
    check("late_done", {31'd0, done}, 32'd1);
    check("late_fault", {31'd0, fault}, 32'd0);
    check("late_wdata", rd_wdata, 32'hDEAD_BEEF);
    tick();

    // LHU at 0x2, rd=0: no write
    issue(1'b1, 3'b101, 32'h0, 32'd2, 32'd0, 5'd0);
    tick();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_8001;
    tick();
    mem_ready = 1'b0;
    check("lhu0_done", {31'd0, done}, 32'd1);
    check("lhu0_rdwe", {31'd0, rd_we}, 32'd0);
    tick();

    // LHU at 0x2, rd=5
    issue(1'b1, 3'b101, 32'h0, 32'd2, 32'd0, 5'd5);
    tick();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_8001;
    tick();
    mem_ready = 1'b0;
    check("lhu5_rdwe", {31'd0, rd_we}, 32'd1);
    check("lhu5_rdout", {27'd0, rd_out}, 32'd5);
    check("lhu5_wdata", rd_wdata, 32'h0000_1234);
    tick();

    // LH at 0x0: low half 0x8001 sign-extends
    issue(1'b1, 3'b001, 32'h0, 32'd0, 32'd0, 5'd6);
    tick();
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_8001;
    tick();
    mem_ready = 1'b0;
    check("lh_wdata", rd_wdata, 32'hFFFF_8001);
    tick();

    // Reset asserted mid-REQ
    issue(1'b1, 3'b010, 32'h700, 32'd0, 32'd0, 5'd8);
    tick();
    start = 1'b0;
    check("rq_req", {31'd0, mem_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    all_quiet("rq_async");
    mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    #1;
    reset = 1'b0;
    tick();
    mem_ready = 1'b0;
    all_quiet("rq_after");

    // Start held high while busy: only one transaction
    issue(1'b1, 3'b010, 32'h500, 32'd0, 32'd0, 5'd2);
    tick();
    base = 32'h600;
    check("bz_addr1", mem_addr, 32'h500);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0042;
    check("bz_addr2", mem_addr, 32'h500);
    tick();
    start = 1'b0; mem_ready = 1'b0;
    check("bz_done", {31'd0, done}, 32'd1);
    check("bz_wdata", rd_wdata, 32'h42);
    tick();
    check("bz_idle", {31'd0, busy}, 32'd0);
    check("bz_noreq", {31'd0, mem_req}, 32'd0);
    tick();
    check("bz_still_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
